// File: rtl/spike_rate_decoder.sv
// Turns one neuron's spike train into a per-window spike count on a valid/ready port,
// and tracks the latest inter-spike interval. Results appear one cycle after the window's last cycle.
module spike_rate_decoder #(
    parameter int WINDOW_CYCLES = 1024,
    parameter int CNT_W         = 8,
    parameter int ISI_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             spike,
    output logic [CNT_W-1:0] rate_data,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic             overrun,
    output logic [ISI_W-1:0] isi_data,
    output logic             isi_valid
);

    localparam int WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [ISI_W-1:0] ISI_MAX  = {ISI_W{1'b1}};

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] spike_cnt;
    logic [ISI_W-1:0] isi_cnt;
    logic             first_seen;

    logic             run;
    logic             complete;
    logic             xfer;
    logic [CNT_W-1:0] result;
    logic [ISI_W-1:0] isi_next;

    always_comb begin
        run      = (state == ST_RUN) && enable;
        complete = run && (win_cnt == WIN_LAST);
        xfer     = rate_valid && rate_ready;
        result   = spike_cnt;
        if (spike && (spike_cnt != CNT_MAX))
            result = spike_cnt + CNT_W'(1);
        isi_next = (isi_cnt == ISI_MAX) ? ISI_MAX : isi_cnt + ISI_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            win_cnt    <= '0;
            spike_cnt  <= '0;
            isi_cnt    <= '0;
            first_seen <= 1'b0;
            rate_data  <= '0;
            rate_valid <= 1'b0;
            overrun    <= 1'b0;
            isi_data   <= '0;
            isi_valid  <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                if (enable) begin
                    state      <= ST_RUN;
                    win_cnt    <= '0;
                    spike_cnt  <= '0;
                    isi_cnt    <= '0;
                    first_seen <= 1'b0;
                    isi_valid  <= 1'b0;
                end
            end else if (!enable) begin
                // Partial window is dropped; counters are re-zeroed on the next entry.
                state <= ST_IDLE;
            end else begin
                if (win_cnt == WIN_LAST) begin
                    win_cnt   <= '0;
                    spike_cnt <= '0;
                end else begin
                    win_cnt   <= win_cnt + WIN_W'(1);
                    spike_cnt <= result;
                end

                if (spike) begin
                    isi_cnt <= ISI_W'(1);
                    if (first_seen) begin
                        isi_data  <= isi_cnt;
                        isi_valid <= 1'b1;
                    end else begin
                        first_seen <= 1'b1;
                    end
                end else begin
                    isi_cnt <= isi_next;
                end
            end

            // The handshake runs in both states so a pending result can drain in IDLE.
            if (complete) begin
                rate_data  <= result;
                rate_valid <= 1'b1;
                if (rate_valid && !rate_ready)
                    overrun <= 1'b1;
            end else if (xfer) begin
                rate_valid <= 1'b0;
            end
        end
    end

endmodule
